// File: rtl/regfile_mp.sv
// Parametrised register file: two combinational read ports, one synchronous write port,
// optional hardwired-zero entry 0, optional write-to-read bypass and a one-entry-per-cycle clear sweep.
module regfile_mp #(
    parameter int N       = 8,
    parameter int A       = 3,
    parameter int ZERO_R0 = 1,
    parameter int BYPASS  = 0
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         write,
    input  logic [A-1:0] Waddr,
    input  logic [N-1:0] Wdata,
    input  logic [A-1:0] Raddr1,
    input  logic [A-1:0] Raddr2,
    output logic [N-1:0] Rdata1,
    output logic [N-1:0] Rdata2,
    input  logic         clear,
    output logic         busy
);

    localparam int           DEPTH    = 2 ** A;
    localparam logic [A-1:0] CNT_LAST = A'(DEPTH - 1);
    localparam logic [A-1:0] CNT_ONE  = A'(1);

    typedef enum logic {
        IDLE  = 1'b0,
        CLEAR = 1'b1
    } state_t;

    state_t        state_r;
    logic [A-1:0]  cnt_r;
    logic          busy_r;
    logic [N-1:0]  mem_r [DEPTH];

    logic          idle_s;
    logic          wr_discard_s;
    logic          wr_en_s;
    logic [N-1:0]  rdata1_s;
    logic [N-1:0]  rdata2_s;

    // Qualify the write: only in IDLE, clear wins, entry 0 writes dropped when hardwired to zero.
    always_comb begin
        idle_s       = (state_r == IDLE);
        wr_discard_s = (ZERO_R0 != 0) && (Waddr == '0);
        if (idle_s && write && !clear && !wr_discard_s) begin
            wr_en_s = 1'b1;
        end else begin
            wr_en_s = 1'b0;
        end
    end

    // Control FSM: reset or a clear request launches a sweep of DEPTH edges.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r <= CLEAR;
            cnt_r   <= '0;
            busy_r  <= 1'b1;
        end else begin
            case (state_r)
                IDLE: begin
                    if (clear) begin
                        state_r <= CLEAR;
                        cnt_r   <= '0;
                        busy_r  <= 1'b1;
                    end
                end
                CLEAR: begin
                    if (cnt_r == CNT_LAST) begin
                        state_r <= IDLE;
                        cnt_r   <= '0;
                        busy_r  <= 1'b0;
                    end else begin
                        cnt_r   <= cnt_r + CNT_ONE;
                    end
                end
                default: begin
                    state_r <= CLEAR;
                    cnt_r   <= '0;
                    busy_r  <= 1'b1;
                end
            endcase
        end
    end

    // Storage update: the sweep owns the array while clearing; contents are never reset directly.
    always_ff @(posedge clk) begin
        if (!reset) begin
            if (state_r == CLEAR) begin
                mem_r[cnt_r] <= '0;
            end else if (wr_en_s) begin
                mem_r[Waddr] <= Wdata;
            end
        end
    end

    // Read muxes: forced to zero during the sweep, zero for entry 0, optional same-cycle forwarding.
    always_comb begin
        rdata1_s = '0;
        rdata2_s = '0;
        if (idle_s) begin
            if ((ZERO_R0 != 0) && (Raddr1 == '0)) begin
                rdata1_s = '0;
            end else if ((BYPASS != 0) && wr_en_s && (Waddr == Raddr1)) begin
                rdata1_s = Wdata;
            end else begin
                rdata1_s = mem_r[Raddr1];
            end
            if ((ZERO_R0 != 0) && (Raddr2 == '0)) begin
                rdata2_s = '0;
            end else if ((BYPASS != 0) && wr_en_s && (Waddr == Raddr2)) begin
                rdata2_s = Wdata;
            end else begin
                rdata2_s = mem_r[Raddr2];
            end
        end else begin
            rdata1_s = '0;
            rdata2_s = '0;
        end
    end

    assign Rdata1 = rdata1_s;
    assign Rdata2 = rdata2_s;
    assign busy   = busy_r;

endmodule

// File: doc/regfile_mp.md
Name: regfile_mp

Overview:
- Parametrised successor to the picoMIPS 8x8 register file, with configurable data width and depth.
- Adds an explicit write address, an optional hardwired-zero register 0 and optional write-to-read bypass.
- Adds a sequential clear engine that zeroes every entry one per cycle after reset or on request.
- Sits between instruction decode and the ALU: two asynchronous read ports, one synchronous write port.

Parameters:
- N, 8, data width in bits.
- A, 3, address width; DEPTH = 2**A entries.
- ZERO_R0, 1, when 1 entry 0 always reads 0 and writes to it are discarded.
- BYPASS, 0, when 1 a same-cycle write to the addressed entry is forwarded to the read port.

Ports:
- clk  input  1  system clock; all state updates on its rising edge.
- reset  input  1  synchronous, active-high reset.
- write  input  1  write enable for the current cycle.
- Waddr  input  A  write address.
- Wdata  input  N  write data.
- Raddr1  input  A  read address, port 1.
- Raddr2  input  A  read address, port 2.
- Rdata1  output  N  read data, port 1 (combinational).
- Rdata2  output  N  read data, port 2 (combinational).
- clear  input  1  request a full clear sweep (single-cycle pulse, sampled at clk edge).
- busy  output  1  high while the clear sweep is running.

Behaviour:
- Storage: DEPTH x N register array. Control state is state in {IDLE, CLEAR} plus a sweep counter cnt of width A.
- Reset: on a clk edge with reset=1, state<=CLEAR and cnt<=0.
  - Array contents are not reset directly; the sweep clears them.
  - busy=1 and Rdata1=Rdata2=0 from that edge onward.
  - While reset is held, cnt stays 0 and no entry is written.
- CLEAR state, each edge with reset=0:
  - entry[cnt]<=0 and cnt<=cnt+1.
  - When cnt==DEPTH-1, the entry is cleared and state<=IDLE, cnt<=0.
  - The sweep therefore takes exactly DEPTH edges after reset deasserts. busy falls after the edge that clears entry DEPTH-1.
- During CLEAR:
  - write is ignored; no entry other than entry[cnt] changes.
  - clear is ignored; the sweep does not restart.
  - Rdata1=Rdata2=0 regardless of address or BYPASS.
- Reset asserted mid-sweep restarts the sweep from cnt=0.
- IDLE state:
  - clear=1 at an edge gives state<=CLEAR, cnt<=0. No entry is cleared on that edge.
  - The sweep then occupies the following DEPTH edges, so busy is high for DEPTH cycles.
  - If clear=1 and write=1 on the same edge, clear has priority and the write is dropped.
  - Otherwise write=1 at an edge gives entry[Waddr]<=Wdata. When ZERO_R0=1 and Waddr==0, the write is discarded.
- Reads, IDLE only:
  - RdataX = entry[RaddrX], combinational, zero latency.
  - ZERO_R0=1 and RaddrX==0: RdataX=0.
  - BYPASS=1, write=1, clear=0, Waddr==RaddrX, and the write is not discarded by ZERO_R0: RdataX=Wdata in the same cycle.
  - BYPASS=0: new data is visible the cycle after the write edge.
  - Both ports may address the same entry and then return identical data.
- Addresses are exactly A bits, so no out-of-range access is possible.
- No X on Rdata1/Rdata2 at any time after the first reset edge.

Test Plan:
- Reset sweep (N=8, A=3): reset high 2 cycles then low -> busy=1 and Rdata=0 throughout; busy low after 8th edge post-deassert; all 8 entries read 0x00.
- Write/read: write 0xA5 to r3 and 0x3C to r7 -> next cycle Raddr1=3 gives 0xA5, Raddr2=7 gives 0x3C; with BYPASS=0, Rdata1 is still 0x00 in the write cycle itself.
- ZERO_R0: write 0xFF to r0 -> Rdata1(Raddr1=0)=0x00, both with BYPASS=1 during the write cycle and on subsequent cycles.
- Bypass (BYPASS=1): write=1, Waddr=5, Wdata=0x77, Raddr1=Raddr2=5 -> Rdata1=Rdata2=0x77 in the same cycle; value persists afterwards.
- Clear priority and ignored writes:
  - Fill r1..r7 with 0x11..0x77, then pulse clear together with write r2=0x99 -> write dropped; busy high 8 cycles.
  - Writes during busy are ignored; after busy falls all entries read 0x00.
- Reset mid-sweep: assert reset at sweep cycle 4 for 1 cycle -> sweep restarts; busy stays high 8 further cycles; second clear pulse during busy has no effect on duration.
